// File: rtl/controle_pilha_pkg.sv
`default_nettype none
// ============================================================================
// Package    : pilha_pkg
// Description: Shared constants and the state type for the stack sequencer.
// Revision   : 1.0 - initial release
// ============================================================================
package pilha_pkg;

  localparam int LARGURA      = 16;  // data width, same as the memory word
  localparam int PROFUNDIDADE = 64;  // number of stack entries
  localparam int TAM_END      = 6;   // log2(PROFUNDIDADE)

  // Memory io pin encoding
  localparam logic MEM_LER      = 1'b0;
  localparam logic MEM_ESCREVER = 1'b1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESCRITA = 2'd1,
    LEITURA = 2'd2,
    CAPTURA = 2'd3
  } estado_t;

endpackage : pilha_pkg
`default_nettype wire

// File: rtl/controle_pilha_if.sv
`default_nettype none
// ============================================================================
// Interfaces : controle_pilha_if, pilha_mem_if
// Description: Request/status bundle between datapath and stack controller,
//              and the address/direction/data bundle towards the stack memory.
// Revision   : 1.0 - initial release
// ============================================================================
interface controle_pilha_if
  import pilha_pkg::*;
#(
  parameter int LARGURA = pilha_pkg::LARGURA,
  parameter int TAM_END = pilha_pkg::TAM_END
);
  logic               push;
  logic               pop;
  logic               clear;
  logic [LARGURA-1:0] push_data;
  logic               ready;
  logic               pop_valid;
  logic [LARGURA-1:0] pop_data;
  logic               full;
  logic               empty;
  logic [TAM_END:0]   count;
  logic               overflow;
  logic               underflow;

  // Datapath side issues requests
  modport master (
    output push, pop, clear, push_data,
    input  ready, pop_valid, pop_data, full, empty, count, overflow, underflow
  );

  // Controller side serves them
  modport slave (
    input  push, pop, clear, push_data,
    output ready, pop_valid, pop_data, full, empty, count, overflow, underflow
  );
endinterface : controle_pilha_if

interface pilha_mem_if
  import pilha_pkg::*;
#(
  parameter int LARGURA = pilha_pkg::LARGURA
);
  logic [LARGURA-1:0] mem_addr;
  logic               mem_io;
  logic [LARGURA-1:0] mem_wdata;
  logic [LARGURA-1:0] mem_rdata;

  // Controller drives address, direction and write data
  modport master (
    output mem_addr, mem_io, mem_wdata,
    input  mem_rdata
  );

  // Memory plus bus driver
  modport slave (
    input  mem_addr, mem_io, mem_wdata,
    output mem_rdata
  );
endinterface : pilha_mem_if
`default_nettype wire

// File: rtl/controle_pilha.sv
`default_nettype none
// ============================================================================
// Module     : controle_pilha
// Description: Stack sequencer for a 64 x 16 registered-read memory. Owns the
//              stack pointer, turns single-cycle push/pop/clear requests into
//              timed memory cycles and reports full/empty/overflow/underflow.
// Revision   : 1.0 - initial release
// ============================================================================
module controle_pilha
  import pilha_pkg::*;
(
  input  wire                 clk,
  input  wire                 rst,
  controle_pilha_if.slave     req,
  pilha_mem_if.master         mem
);

  localparam logic [TAM_END:0] SP_UM    = (TAM_END+1)'(1);
  localparam logic [TAM_END:0] SP_CHEIO = (TAM_END+1)'(PROFUNDIDADE);

  estado_t            state_q, state_d;
  logic [TAM_END:0]   sp_q, sp_d;
  logic [LARGURA-1:0] pop_data_q, pop_data_d;
  logic [LARGURA-1:0] mem_wdata_q, mem_wdata_d;
  logic               pop_valid_q, pop_valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic               empty;
  logic               full;
  logic [TAM_END-1:0] idx_topo;
  logic [TAM_END-1:0] idx_acesso;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_CHEIO);
  assign idx_topo = TAM_END'(sp_q - SP_UM);

  // Memory index from registered state only: writes go to the free slot, every
  // other state points at the top of stack (slot 0 when the stack is empty).
  always_comb begin
    if (state_q == ESCRITA) begin
      idx_acesso = sp_q[TAM_END-1:0];
    end else if (empty) begin
      idx_acesso = '0;
    end else begin
      idx_acesso = idx_topo;
    end
  end

  assign mem.mem_addr  = LARGURA'(idx_acesso);
  assign mem.mem_io    = (state_q == ESCRITA) ? MEM_ESCREVER : MEM_LER;
  assign mem.mem_wdata = mem_wdata_q;

  assign req.ready     = (state_q == OCIOSO);
  assign req.pop_valid = pop_valid_q;
  assign req.pop_data  = pop_data_q;
  assign req.full      = full;
  assign req.empty     = empty;
  assign req.count     = sp_q;
  assign req.overflow  = overflow_q;
  assign req.underflow = underflow_q;

  // Next-state logic: request arbitration (clear > pop > push) and sequencing
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    mem_wdata_d = mem_wdata_q;
    pop_valid_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (req.clear) begin
          sp_d = '0;
        end else if (req.pop) begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            state_d = LEITURA;
          end
        end else if (req.push) begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            mem_wdata_d = req.push_data;
            state_d     = ESCRITA;
          end
        end
      end
      ESCRITA: begin
        // Memory captures the word at this closing edge
        sp_d    = sp_q + SP_UM;
        state_d = OCIOSO;
      end
      LEITURA: begin
        // Memory registers the top entry at this closing edge
        sp_d    = sp_q - SP_UM;
        state_d = CAPTURA;
      end
      CAPTURA: begin
        pop_data_d  = mem.mem_rdata;
        pop_valid_d = 1'b1;
        state_d     = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OCIOSO;
      sp_q        <= '0;
      pop_data_q  <= '0;
      mem_wdata_q <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      mem_wdata_q <= mem_wdata_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule : controle_pilha
`default_nettype wire

// File: tb/tb_controle_pilha.sv
`default_nettype none
// ============================================================================
// Module     : tb_controle_pilha
// Description: Bench for controle_pilha with a 64 x 16 registered-read memory
//              on a shared tri-state Data bus.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_controle_pilha;
  import pilha_pkg::*;

  localparam int N = 1024;  // cycle horizon of the expectation tables

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controle_pilha_if req_if ();
  pilha_mem_if      mem_if ();

  controle_pilha dut (
    .clk (clk),
    .rst (rst),
    .req (req_if.slave),
    .mem (mem_if.master)
  );

  // Stack memory: write when io = 1, registered read otherwise
  logic [15:0] mem_arr [64];
  logic [15:0] mem_q;
  tri   [15:0] data_bus;

  assign data_bus = mem_if.mem_io ? mem_if.mem_wdata : 16'bz;
  assign data_bus = mem_if.mem_io ? 16'bz : mem_q;
  assign mem_if.mem_rdata = data_bus;

  always @(posedge clk) begin
    if (mem_if.mem_io) mem_arr[mem_if.mem_addr[5:0]] <= data_bus;
    else               mem_q <= mem_arr[mem_if.mem_addr[5:0]];
  end

  // Expected behaviour per cycle, filled in when a request is accepted
  int  e_cnt_set [N];  // count takes this value from the cycle on (-1: keep)
  int  e_pd_set  [N];  // pop_data takes this value from the cycle on (-1: keep)
  int  e_addr    [N];  // required mem_addr (-1: idle rule or don't care)
  int  e_wd      [N];
  bit  e_busy    [N];
  bit  e_io      [N];
  bit  e_pv      [N];
  bit  e_ov      [N];
  bit  e_un      [N];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 0;
  int  stk[$];
  int  m_cnt = 0;
  int  m_pd  = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_tables(input int from);
    for (int i = from; i < N; i++) begin
      e_cnt_set[i] = -1; e_pd_set[i] = -1; e_addr[i] = -1; e_wd[i] = 0;
      e_busy[i] = 0; e_io[i] = 0; e_pv[i] = 0; e_ov[i] = 0; e_un[i] = 0;
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en && cyc < N) begin
      if (e_cnt_set[cyc] >= 0) m_cnt = e_cnt_set[cyc];
      if (e_pd_set[cyc]  >= 0) m_pd  = e_pd_set[cyc];
      chk("count", 32'(req_if.count), m_cnt);
      chk("empty", 32'(req_if.empty), 32'(m_cnt == 0));
      chk("full", 32'(req_if.full), 32'(m_cnt == 64));
      chk("ready", 32'(req_if.ready), 32'(!e_busy[cyc]));
      chk("mem_io", 32'(mem_if.mem_io), 32'(e_io[cyc]));
      if (e_addr[cyc] >= 0)
        chk("mem_addr", 32'(mem_if.mem_addr), e_addr[cyc]);
      else if (!e_busy[cyc])
        chk("mem_addr_idle", 32'(mem_if.mem_addr), (m_cnt == 0) ? 0 : m_cnt - 1);
      if (e_io[cyc]) chk("mem_wdata", 32'(mem_if.mem_wdata), e_wd[cyc]);
      chk("pop_valid", 32'(req_if.pop_valid), 32'(e_pv[cyc]));
      chk("pop_data", 32'(req_if.pop_data), m_pd);
      chk("overflow", 32'(req_if.overflow), 32'(e_ov[cyc]));
      chk("underflow", 32'(req_if.underflow), 32'(e_un[cyc]));
    end
  end

  // One cycle of stimulus; updates the model if the controller is idle.
  // acc reports whether the highest-priority request present was taken.
  task automatic step(input bit p, input bit q, input bit cl, input logic [15:0] d,
                      output bit acc);
    int c;
    int v;
    c   = cyc;
    acc = 1'b0;
    if (c + 4 >= N) begin
      $display("FAIL horizon: cycle %0d beyond table size %0d", c, N);
      $fatal(1, "bench horizon exceeded");
    end
    req_if.push = p; req_if.pop = q; req_if.clear = cl; req_if.push_data = d;
    if (!e_busy[c]) begin
      if (cl) begin
        acc = 1'b1;
        stk.delete();
        e_cnt_set[c+1] = 0;
      end else if (q) begin
        acc = 1'b1;
        if (stk.size() == 0) begin
          e_un[c+1] = 1'b1;
        end else begin
          e_busy[c+1] = 1'b1; e_busy[c+2] = 1'b1;
          e_addr[c+1] = stk.size() - 1;
          v = stk.pop_back();
          e_cnt_set[c+2] = stk.size();
          e_pv[c+3] = 1'b1;
          e_pd_set[c+3] = v;
        end
      end else if (p) begin
        acc = 1'b1;
        if (stk.size() == 64) begin
          e_ov[c+1] = 1'b1;
        end else begin
          e_busy[c+1] = 1'b1;
          e_io[c+1]   = 1'b1;
          e_addr[c+1] = stk.size();
          e_wd[c+1]   = int'(d);
          stk.push_back(int'(d));
          e_cnt_set[c+2] = stk.size();
        end
      end
    end
    @(posedge clk); #1;
    req_if.push = 1'b0; req_if.pop = 1'b0; req_if.clear = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, acc);
  endtask

  task automatic push_op(input logic [15:0] d);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 10) begin
      step(1, 0, 0, d, acc);
      tries++;
    end
    if (!acc) chk("push_timeout", 32'(acc), 32'd1);
  endtask

  // Pop, then measure the pop_valid latency and the value delivered
  task automatic pop_expect(input logic [15:0] exp);
    bit acc;
    int tries;
    int lat;
    acc = 0;
    tries = 0;
    lat = 0;
    while (!acc && tries < 10) begin
      step(0, 1, 0, 16'h0, acc);
      tries++;
    end
    if (!acc) chk("pop_timeout", 32'(acc), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (req_if.pop_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk("pop_latency_lit", lat, 3);
    chk("pop_data_lit", 32'(req_if.pop_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic reset_cycle();
    int c;
    c = cyc;
    rst = 1'b1;
    req_if.push = 1'b0; req_if.pop = 1'b0; req_if.clear = 1'b0;
    clear_tables(c + 1);
    e_cnt_set[c+1] = 0;
    e_pd_set[c+1]  = 0;
    stk.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    int held;
    for (int i = 0; i < 64; i++) mem_arr[i] = 16'h0;
    mem_q = 16'h0;
    clear_tables(0);
    rst = 1'b1;
    req_if.push = 1'b0; req_if.pop = 1'b0; req_if.clear = 1'b0;
    req_if.push_data = 16'h0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0; m_pd = 0;
    chk_en = 1'b1;

    // Reset state held through idle cycles
    idle(3);
    @(negedge clk);
    chk("reset_empty_lit", 32'(req_if.empty), 1);
    chk("reset_count_lit", 32'(req_if.count), 0);
    chk("reset_ready_lit", 32'(req_if.ready), 1);
    @(posedge clk); #1;

    // LIFO order on three entries
    push_op(16'h00A1);
    push_op(16'h00B2);
    push_op(16'h00C3);
    idle(1);
    @(negedge clk);
    chk("three_count_lit", 32'(req_if.count), 3);
    @(posedge clk); #1;
    pop_expect(16'h00C3);
    pop_expect(16'h00B2);
    pop_expect(16'h00A1);
    @(negedge clk);
    chk("drained_empty_lit", 32'(req_if.empty), 1);
    @(posedge clk); #1;

    // Fill to capacity, then overflow
    for (int i = 0; i < 64; i++) push_op(16'(i));
    idle(1);
    @(negedge clk);
    chk("filled_full_lit", 32'(req_if.full), 1);
    @(posedge clk); #1;
    step(1, 0, 0, 16'hDEAD, acc);
    @(negedge clk);
    chk("overflow_lit", 32'(req_if.overflow), 1);
    chk("overflow_noio_lit", 32'(mem_if.mem_io), 0);
    @(posedge clk); #1;
    idle(1);
    @(negedge clk);
    chk("overflow_count_lit", 32'(req_if.count), 64);
    @(posedge clk); #1;
    pop_expect(16'h003F);

    // Clear, then pop on empty
    step(0, 0, 1, 16'h0, acc);
    step(0, 1, 0, 16'h0, acc);
    @(negedge clk);
    chk("underflow_lit", 32'(req_if.underflow), 1);
    chk("underflow_count_lit", 32'(req_if.count), 0);
    @(posedge clk); #1;
    idle(4);

    // Simultaneous push and pop: pop wins, push retries until ready
    push_op(16'h0010);
    push_op(16'h0011);
    idle(1);
    step(1, 1, 0, 16'h0055, acc);
    held = 0;
    acc  = 0;
    while (!acc && held < 10) begin
      step(1, 0, 0, 16'h0055, acc);
      held++;
    end
    chk("push_retry_cycles_lit", held, 3);
    idle(2);
    @(negedge clk);
    chk("pushpop_count_lit", 32'(req_if.count), 2);
    chk("pushpop_data_lit", 32'(req_if.pop_data), 32'h0011);
    @(posedge clk); #1;

    // Reset during the write cycle
    step(1, 0, 0, 16'h1234, acc);
    reset_cycle();
    @(negedge clk);
    chk("midreset_count_lit", 32'(req_if.count), 0);
    chk("midreset_ready_lit", 32'(req_if.ready), 1);
    @(posedge clk); #1;

    // Clear with five entries
    for (int i = 1; i <= 5; i++) push_op(16'(i));
    idle(1);
    @(negedge clk);
    chk("five_count_lit", 32'(req_if.count), 5);
    @(posedge clk); #1;
    step(0, 0, 1, 16'h0, acc);
    @(negedge clk);
    chk("clear_count_lit", 32'(req_if.count), 0);
    @(posedge clk); #1;
    idle(3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_controle_pilha
`default_nettype wire
